psram_rd_arb: RTL and testbench
===============================

// Module: psram_rd_arb
// PURPOSE
//  Two-requester arbiter for the single AXI4 read port (AR/R) of psram_ctrl.
//  Requester 0 is the video2 frame fetcher; requester 1 is a secondary reader (capture playback/debug).
//  Burst ownership is tracked in an in-order owner FIFO so R beats return to the correct requester.
//  Sits in the clk domain between the requesters and psram_ctrl.
// PARAMETERS
//  BURST_LEN   4   beats per read burst; psram_ctrl arlen is tied to this value
//  MAX_OUTST   4   max bursts in flight (owner FIFO depth, power of 2)
// PORTS
//  clk           in   1   system clock (48 MHz)
//  reset         in   1   synchronous, active-high reset
//  psram_ready   in   1   psram_ctrl accepts requests; no new grant while low
//  m0_araddr     in   25  requester 0 read address
//  m0_arvalid    in   1   requester 0 address valid
//  m0_arready    out  1   requester 0 address accepted
//  m0_rdata      out  18  requester 0 read data
//  m0_rvalid     out  1   requester 0 read data valid
//  m1_*          -    -   same five signals for requester 1
//  s_araddr      out  25  to psram_ctrl araddr
//  s_arvalid     out  1   to psram_ctrl arvalid
//  s_arready     in   1   from psram_ctrl arready
//  s_rdata       in   18  from psram_ctrl rdata (rready tied 1)
//  s_rvalid      in   1   from psram_ctrl rvalid
//  err_orphan    out  1   sticky: R beat arrived while the owner FIFO was empty
// BEHAVIOUR
//  Clock/reset: one clock, clk. Reset is synchronous and active-high.
//  Reset values: s_arvalid=0, s_araddr=0, mX_arready=0, mX_rvalid=0, mX_rdata=0, err_orphan=0.
//    FIFO, beat counter and RR pointer are cleared.
//  Reset mid-burst: in-flight state is discarded. Later orphan beats set err_orphan and are dropped.
//  AR FSM states: IDLE, ISSUE.
//    IDLE -> ISSUE when psram_ready=1, the FIFO is not full, and any mX_arvalid=1.
//      The winner's address is latched into s_araddr. s_arvalid=1 from the next cycle.
//    ISSUE holds s_arvalid and s_araddr stable until s_arready=1.
//      In that cycle mX_arready=1 for the winner only (combinational from s_arready).
//      The owner ID is pushed; the FSM returns to IDLE.
//    Minimum AR spacing is 2 cycles. The grant never changes while in ISSUE.
//  Arbitration: round-robin. When both request, the winner is the requester not granted last.
//    The pointer updates only on the AR handshake.
//  R routing: on s_rvalid, the beat goes to the owner at the FIFO head.
//    mX_rdata/mX_rvalid are registered, giving 1 cycle latency.
//    The other requester's rvalid stays 0; its rdata holds.
//  The beat counter counts 0..BURST_LEN-1. The FIFO pops on the last beat.
//  A push and a pop in the same cycle are allowed; occupancy is unchanged.
//  Full: at MAX_OUTST outstanding bursts, no grant is issued; requests wait.
//  Empty: s_rvalid with an empty FIFO sets err_orphan (cleared only by reset); the beat is dropped.
//  No backpressure on R; requesters must always accept rvalid.
// CONFIGURATION
//  PSRAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a simultaneous request.
//    The RR pointer is removed (video fetch has hard deadlines).
//  Not defined: round-robin as above.
// STRUCTURE
//  Shared package psram_pkg:
//    typedef psram_addr_t = logic [24:0]
//    typedef psram_data_t = logic [17:0]
//    localparam PSRAM_BURST_LEN = 4
//    enum arb_state_t {IDLE, ISSUE}
//  Sub-module: psram_arb_owner_fifo (1-bit wide, MAX_OUTST deep, push/pop/full/empty).
// TESTING
//  1. Single req: m0 araddr=0x000_1000 with psram_ready=1 and s_arready on the 2nd ISSUE cycle.
//     -> s_araddr=0x0001000; one m0_arready pulse; 4 s_rvalid beats -> 4 m0_rvalid, 1 cycle late; m1_rvalid=0.
//  2. Both request continuously, s_arready always 1.
//     -> grants alternate m0,m1,m0,m1 (macro off); with the macro on, all grants go to m0.
//  3. 4 bursts issued, R withheld.
//     -> 5th request stalls in IDLE. Last beat of burst 1 pops; the request is then granted next cycle.
//  4. Interleaved owners m0,m1,m0 with R beats back-to-back.
//     -> exactly 4 beats per owner, in order; same-cycle push+pop keeps occupancy correct.
//  5. psram_ready=0 with m1_arvalid=1 -> s_arvalid stays 0; raise psram_ready -> grant follows.
//  6. Reset pulse mid-burst, then 2 remaining s_rvalid beats.
//     -> no mX_rvalid; err_orphan=1 until the next reset.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM read-side arbitration logic.
package psram_pkg;

    typedef logic [24:0] psram_addr_t;
    typedef logic [17:0] psram_data_t;

    localparam int PSRAM_BURST_LEN = 4;
    localparam int PSRAM_MAX_OUTST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/psram_arb_owner_fifo.sv
// In-order owner FIFO: one bit per outstanding burst recording which requester
// issued it, so returning R beats can be steered back to the right place.
module psram_arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Owner storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_id;
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head_id = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/psram_rd_arb.sv
// Two-requester arbiter for the psram_ctrl AXI4 read port (AR/R).
// Requester 0 is the video frame fetcher, requester 1 a secondary reader.
// Burst owners are queued in order so R beats return to the issuing requester.
// Optional build macro PSRAM_ARB_FIXED_PRIO_EN: requester 0 always wins a
// simultaneous request and the round-robin pointer is removed.
module psram_rd_arb
    import psram_pkg::*;
#(
    parameter int BURST_LEN = PSRAM_BURST_LEN,
    parameter int MAX_OUTST = PSRAM_MAX_OUTST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psram_ready,
    input  psram_addr_t m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output psram_data_t m0_rdata,
    output logic        m0_rvalid,
    input  psram_addr_t m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output psram_data_t m1_rdata,
    output logic        m1_rvalid,
    output psram_addr_t s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  psram_data_t s_rdata,
    input  logic        s_rvalid,
    output logic        err_orphan
);

    localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

    arb_state_t     state;
    logic           grant_id;
    logic           win_id;
    logic           req_any;
    logic           push;
    logic           pop;
    logic           head_id;
    logic           fifo_full;
    logic           fifo_empty;
    logic [BCW-1:0] beat_cnt;

`ifndef PSRAM_ARB_FIXED_PRIO_EN
    logic           rr_last;
`endif

    // Pick the winner among the current requests.
    always_comb begin
        req_any = m0_arvalid | m1_arvalid;
`ifdef PSRAM_ARB_FIXED_PRIO_EN
        win_id  = ~m0_arvalid;
`else
        if (m0_arvalid && m1_arvalid) begin
            win_id = ~rr_last;
        end else begin
            win_id = ~m0_arvalid;
        end
`endif
    end

    // The AR handshake pushes the owner; arready is steered to the latched winner only.
    assign push       = (state == ISSUE) && s_arready;
    assign m0_arready = push && !grant_id;
    assign m1_arready = push &&  grant_id;
    assign pop        = s_rvalid && !fifo_empty && (beat_cnt == BEAT_LAST);

    // AR FSM: latch winner and address in IDLE, hold them stable through ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_arvalid <= 1'b0;
            s_araddr  <= '0;
            grant_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (psram_ready && !fifo_full && req_any) begin
                        state     <= ISSUE;
                        s_arvalid <= 1'b1;
                        grant_id  <= win_id;
                        s_araddr  <= win_id ? m1_araddr : m0_araddr;
                    end
                end
                ISSUE: begin
                    if (s_arready) begin
                        state     <= IDLE;
                        s_arvalid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    s_arvalid <= 1'b0;
                end
            endcase
        end
    end

`ifndef PSRAM_ARB_FIXED_PRIO_EN
    // Round-robin pointer remembers the last requester that completed an AR handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (push) begin
            rr_last <= grant_id;
        end
    end
`endif

    // R routing: steer each beat to the head owner, count beats, flag orphans.
    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            beat_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (s_rvalid) begin
                if (fifo_empty) begin
                    err_orphan <= 1'b1;
                end else begin
                    if (head_id) begin
                        m1_rvalid <= 1'b1;
                        m1_rdata  <= s_rdata;
                    end else begin
                        m0_rvalid <= 1'b1;
                        m0_rdata  <= s_rdata;
                    end
                    beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
                end
            end
        end
    end

    psram_arb_owner_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_owner_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .push_id(grant_id),
        .pop    (pop),
        .head_id(head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_psram_rd_arb.sv
// Directed self-checking bench for psram_rd_arb.
// Honours PSRAM_ARB_FIXED_PRIO_EN when selecting expected grant order.
module tb_psram_rd_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        psram_ready;
    logic [24:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [17:0] m0_rdata, m1_rdata, s_rdata;
    logic        m0_rvalid, m1_rvalid;
    logic        s_arvalid, s_arready, s_rvalid;
    logic        err_orphan;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic        exp_g   [4];
    logic        exp_own [5];
    logic [17:0] last0, last1, exp_d;
    logic        gid, own;
    int          ng;

    psram_rd_arb dut (
        .clk        (clk),
        .reset      (reset),
        .psram_ready(psram_ready),
        .m0_araddr  (m0_araddr),
        .m0_arvalid (m0_arvalid),
        .m0_arready (m0_arready),
        .m0_rdata   (m0_rdata),
        .m0_rvalid  (m0_rvalid),
        .m1_araddr  (m1_araddr),
        .m1_arvalid (m1_arvalid),
        .m1_arready (m1_arready),
        .m1_rdata   (m1_rdata),
        .m1_rvalid  (m1_rvalid),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rvalid   (s_rvalid),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_s_arvalid"},  s_arvalid,  0);
        chk({pfx, "_s_araddr"},   s_araddr,   0);
        chk({pfx, "_m0_arready"}, m0_arready, 0);
        chk({pfx, "_m1_arready"}, m1_arready, 0);
        chk({pfx, "_m0_rvalid"},  m0_rvalid,  0);
        chk({pfx, "_m1_rvalid"},  m1_rvalid,  0);
        chk({pfx, "_m0_rdata"},   m0_rdata,   0);
        chk({pfx, "_m1_rdata"},   m1_rdata,   0);
        chk({pfx, "_err_orphan"}, err_orphan, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
        exp_g   = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_g   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        psram_ready = 1'b1;
        m0_araddr = '0; m0_arvalid = 1'b0;
        m1_araddr = '0; m1_arvalid = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

        do_reset(2);
        chk_reset_state("rst");

        // Test 1: single request from m0, arready on the second ISSUE cycle
        m0_araddr  = 25'h0001000;
        m0_arvalid = 1'b1;
        tick();
        chk("t1_arvalid_c1", s_arvalid, 1);
        chk("t1_araddr",     s_araddr, 32'h0001000);
        chk("t1_m0_arready_c1", m0_arready, 0);
        tick();
        chk("t1_arvalid_c2", s_arvalid, 1);
        s_arready = 1'b1;
        #1;
        chk("t1_m0_arready", m0_arready, 1);
        chk("t1_m1_arready", m1_arready, 0);
        tick();
        m0_arvalid = 1'b0;
        s_arready  = 1'b0;
        chk("t1_arvalid_done", s_arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            s_rdata  = 18'(32'h100 + i);
            s_rvalid = 1'b1;
            #1;
            chk($sformatf("t1_m0_rvalid_pre%0d", i), m0_rvalid, (i == 0) ? 0 : 1);
            tick();
            chk($sformatf("t1_m0_rvalid%0d", i), m0_rvalid, 1);
            chk($sformatf("t1_m0_rdata%0d", i),  m0_rdata, 32'h100 + i);
            chk($sformatf("t1_m1_rvalid%0d", i), m1_rvalid, 0);
        end
        s_rvalid = 1'b0;
        tick();
        chk("t1_m0_rvalid_end", m0_rvalid, 0);
        chk("t1_err_orphan",    err_orphan, 0);

        // Test 2: both request continuously with arready always high
        do_reset(1);
        m0_araddr = 25'h0002000; m1_araddr = 25'h0003000;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        s_arready = 1'b1;
        ng = 0;
        for (int c = 0; c < 16 && ng < 4; c++) begin
            tick();
            if (m0_arready || m1_arready) begin
                gid = m1_arready;
                chk($sformatf("t2_onehot%0d", ng), m0_arready & m1_arready, 0);
                chk($sformatf("t2_grant%0d", ng), gid, exp_g[ng]);
                chk($sformatf("t2_addr%0d", ng), s_araddr, exp_g[ng] ? 32'h0003000 : 32'h0002000);
                ng++;
            end
        end
        chk("t2_grant_count", ng, 4);
        tick();
        m1_arvalid = 1'b0;

        // Test 3: four bursts outstanding, fifth request must wait for a pop
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("t3_stall%0d", c), s_arvalid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            s_rdata  = 18'(32'h200 + i);
            s_rvalid = 1'b1;
            tick();
            chk($sformatf("t3_m0_rvalid%0d", i), m0_rvalid, 1);
            chk($sformatf("t3_m0_rdata%0d", i),  m0_rdata, 32'h200 + i);
            chk($sformatf("t3_m1_rvalid%0d", i), m1_rvalid, 0);
            chk($sformatf("t3_still_stalled%0d", i), s_arvalid, 0);
        end
        s_rvalid = 1'b0;
        tick();
        chk("t3_grant_after_pop", s_arvalid, 1);
        chk("t3_addr", s_araddr, 32'h0002000);
        chk("t3_m0_arready", m0_arready, 1);
        tick();
        m0_arvalid = 1'b0;
        s_arready  = 1'b0;
        last0 = 18'h203;
        last1 = 18'h000;

        // Test 4: back-to-back beats across interleaved owners, push and pop in one cycle
        m1_araddr  = 25'h0004000;
        m1_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_rdata  = 18'(32'h300 + i);
            s_rvalid = 1'b1;
            if (i == 7) begin
                s_arready = 1'b1;
                #1;
                chk("t4_m1_arready", m1_arready, 1);
                chk("t4_m0_arready", m0_arready, 0);
            end
            tick();
            if (i == 7) begin
                s_arready  = 1'b0;
                m1_arvalid = 1'b0;
            end
            own   = exp_own[i / 4];
            exp_d = 18'(32'h300 + i);
            if (own) begin
                chk($sformatf("t4_m1_rvalid%0d", i), m1_rvalid, 1);
                chk($sformatf("t4_m1_rdata%0d", i),  m1_rdata, exp_d);
                chk($sformatf("t4_m0_rvalid%0d", i), m0_rvalid, 0);
                chk($sformatf("t4_m0_hold%0d", i),   m0_rdata, last0);
                last1 = exp_d;
            end else begin
                chk($sformatf("t4_m0_rvalid%0d", i), m0_rvalid, 1);
                chk($sformatf("t4_m0_rdata%0d", i),  m0_rdata, exp_d);
                chk($sformatf("t4_m1_rvalid%0d", i), m1_rvalid, 0);
                chk($sformatf("t4_m1_hold%0d", i),   m1_rdata, last1);
                last0 = exp_d;
            end
            if (i == 3) chk("t4_full_no_grant", s_arvalid, 0);
            if (i == 4) begin
                chk("t4_grant_m1", s_arvalid, 1);
                chk("t4_addr_m1",  s_araddr, 32'h0004000);
            end
        end
        s_rvalid = 1'b0;
        tick();
        chk("t4_m0_rvalid_end", m0_rvalid, 0);
        chk("t4_m1_rvalid_end", m1_rvalid, 0);
        chk("t4_no_orphan",     err_orphan, 0);
        s_rdata  = 18'h3ff;
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
        chk("t4_empty_orphan",   err_orphan, 1);
        chk("t4_orphan_m0_rv",   m0_rvalid, 0);
        chk("t4_orphan_m1_rv",   m1_rvalid, 0);
        repeat (3) tick();
        chk("t4_orphan_sticky",  err_orphan, 1);

        // Test 5: psram_ready low blocks the grant
        do_reset(1);
        chk("t5_orphan_cleared", err_orphan, 0);
        psram_ready = 1'b0;
        m1_araddr   = 25'h0005000;
        m1_arvalid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t5_blocked%0d", c), s_arvalid, 0);
        end
        psram_ready = 1'b1;
        tick();
        chk("t5_grant",  s_arvalid, 1);
        chk("t5_addr",   s_araddr, 32'h0005000);
        s_arready = 1'b1;
        #1;
        chk("t5_m1_arready", m1_arready, 1);
        tick();
        m1_arvalid = 1'b0;
        s_arready  = 1'b0;

        // Test 6: reset in the middle of a burst, trailing beats become orphans
        for (int i = 0; i < 2; i++) begin
            s_rdata  = 18'(32'h500 + i);
            s_rvalid = 1'b1;
            tick();
            chk($sformatf("t6_m1_rvalid%0d", i), m1_rvalid, 1);
            chk($sformatf("t6_m1_rdata%0d", i),  m1_rdata, 32'h500 + i);
        end
        s_rvalid = 1'b0;
        do_reset(1);
        chk_reset_state("t6_rst");
        for (int i = 2; i < 4; i++) begin
            s_rdata  = 18'(32'h500 + i);
            s_rvalid = 1'b1;
            tick();
            chk($sformatf("t6_m0_rvalid%0d", i), m0_rvalid, 0);
            chk($sformatf("t6_m1_rvalid%0d", i), m1_rvalid, 0);
            chk($sformatf("t6_orphan%0d", i),    err_orphan, 1);
        end
        s_rvalid = 1'b0;
        repeat (3) tick();
        chk("t6_orphan_sticky", err_orphan, 1);
        chk("t6_m1_rdata_hold", m1_rdata, 0);
        do_reset(1);
        chk("t6_orphan_cleared", err_orphan, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
